mod9_seq_checker: RTL and testbench
===================================

Name: mod9_seq_checker

Overview:
Downstream consumer of the mod-9 counter output. It samples the counter value, locks onto the expected 0..8 wrap-around sequence and produces one-cycle wrap pulses, a wrap tally and error flags/counts. It is the self-check stage placed after the counter in the ADLD lab chain. Benches and the top-level use it to prove the counter sequence on-chip rather than by reading waveforms.

Parameters:
MODULUS, 9, counter modulus; the legal sequence is 0..MODULUS-1 with wrap to 0
IN_W, 5, width of the sampled counter value
CNT_W, 8, width of wrap_count and err_count
LOCK_LEN, 3, consecutive correct transitions required to enter LOCK

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cnt_in  input  IN_W  counter value from upstream, already stable and synchronous to clk
cnt_valid  input  1  qualifies cnt_in; a sample is taken only when cnt_valid=1
err_clr  input  1  clears err_sticky and err_count
locked  output  1  1 while in LOCK
wrap_pulse  output  1  one-cycle pulse on a legal MODULUS-1 -> 0 transition while locked
wrap_count  output  CNT_W  number of legal wraps; rolls over modulo 2^CNT_W
err_pulse  output  1  one-cycle pulse on a sequence error while locked
err_sticky  output  1  set by any error; held until err_clr or rst
err_count  output  CNT_W  number of errors; saturates at 2^CNT_W-1

Behaviour:
- All outputs are registered. Each response appears on the clock edge after the sample that caused it (latency 1).
- rst=1 at an edge forces: state=ACQ, have_prev=0, run=0, prev=0, and every output 0. rst has priority over all other inputs, including mid-LOCK.
- Cycles with cnt_valid=0 are ignored: prev, run and state hold, and the pulses are 0.
- Expected next value: exp = (prev == MODULUS-1) ? 0 : prev+1. A sample is correct iff cnt_in < MODULUS and cnt_in == exp.
- ACQ state:
  - First valid sample after reset or after an error stores prev and sets have_prev=1. It is not compared.
  - Each later valid sample that is correct increments run.
  - An incorrect sample, including an out-of-range one, sets run=0. No error is reported in ACQ.
  - prev is always updated to cnt_in.
  - When run reaches LOCK_LEN, the next state is LOCK and locked=1.
  - wrap_pulse is never asserted in ACQ.
- LOCK state:
  - A correct sample updates prev. If it is a correct 0 following MODULUS-1, wrap_pulse=1 and wrap_count increments, wrapping.
  - An incorrect sample causes: err_pulse=1, err_sticky=1, err_count+1 (saturating), locked=0, next state ACQ, run=0, have_prev=1, prev=cnt_in. The bad sample seeds the resync.
  - An incorrect 0 is never counted as a wrap. Error takes precedence over wrap.
- err_clr=1: err_sticky=0 and err_count=0.
  - If an error occurs in the same cycle, the error wins: err_sticky=1, err_count=1.
  - err_clr does not affect state, locked, or the wrap outputs.
- Width rule: compare cnt_in zero-extended against MODULUS. Requires MODULUS <= 2^IN_W.

Test Plan:
1. Acquire: rst 2 cycles, then valid samples 0,1,2,3 -> locked=0 through the sample of 2; locked=1 on the edge after sample 3; err_sticky=0.
2. Wrap: continue 4,5,6,7,8,0 -> wrap_pulse=1 for exactly one cycle after sample 0; wrap_count=1; continue to a second 8->0 -> wrap_count=2.
3. Sequence error: in LOCK at prev=2, drive 5 -> err_pulse one cycle, err_sticky=1, err_count=1, locked=0; then 6,7,8 -> locked=1 after 8, no further errors.
4. Out-of-range and gaps: in LOCK at prev=4, drop cnt_valid for 3 cycles with cnt_in=12 -> no change; then valid 12 -> error, err_count increments; in ACQ feed 12 -> run resets, no error.
5. Clear and saturation: force 255 errors -> err_count holds 255 on the 256th; err_clr alone -> count 0, sticky 0; err_clr together with an error -> sticky 1, count 1.
6. Reset mid-operation: locked, wrap_count=5, err_count=2, assert rst one cycle -> all outputs 0 on the next edge; 0,1,2,3 relocks normally.

Source files
------------

// File: rtl/mod9_seq_checker.sv
// Self-check stage that follows the mod-9 counter and locks onto its 0..8 wrap sequence.
// Reports one-cycle wrap and error pulses, a wrap tally and a saturating error tally.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, wins over everything
//   cnt_in     in   [IN_W]  counter value from upstream
//   cnt_valid  in   qualifies cnt_in
//   err_clr    in   clears err_sticky / err_count (a same-cycle error wins)
//   locked     out  1 while in LOCK
//   wrap_pulse out  one cycle on a legal MODULUS-1 -> 0 step while locked
//   wrap_count out  [CNT_W] legal wraps, rolls over
//   err_pulse  out  one cycle on a sequence error while locked
//   err_sticky out  set by any error, held until err_clr or rst
//   err_count  out  [CNT_W] errors, saturating
// All outputs are registered: response appears one edge after its sample.
// MODULUS must not exceed 2**IN_W.

module mod9_seq_checker #(
  parameter int unsigned MODULUS  = 9,
  parameter int unsigned IN_W     = 5,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  cnt_in,
  input  logic             cnt_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned RUN_W = $clog2(LOCK_LEN + 1);

  // One extra bit so prev+1 never aliases back into range
  // (e.g. prev=31 must not predict 0).
  localparam logic [IN_W:0] LP_MOD  = (IN_W+1)'(MODULUS);
  localparam logic [IN_W:0] LP_LAST = (IN_W+1)'(MODULUS - 1);
  localparam logic [IN_W:0] LP_ONE  = (IN_W+1)'(1);

  localparam logic [RUN_W-1:0] LP_RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] LP_LOCK_LEN = RUN_W'(LOCK_LEN);

  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  typedef enum logic {
    ACQ  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_have_prev;
  logic [RUN_W-1:0] r_run;
  logic [IN_W-1:0]  r_prev;
  logic             r_locked;
  logic             r_wrap_pulse;
  logic [CNT_W-1:0] r_wrap_count;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_count;

  state_t           w_state_nxt;
  logic             w_have_prev_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [IN_W-1:0]  w_prev_nxt;
  logic             w_locked_nxt;
  logic             w_wrap_pulse_nxt;
  logic [CNT_W-1:0] w_wrap_count_nxt;
  logic             w_err_pulse_nxt;
  logic             w_err_sticky_nxt;
  logic [CNT_W-1:0] w_err_count_nxt;
  logic             w_seq_err;

  logic [IN_W:0]    w_cnt_ext;
  logic [IN_W:0]    w_prev_ext;
  logic [IN_W:0]    w_exp;
  logic             w_prev_last;
  logic             w_correct;
  logic [RUN_W-1:0] w_run_inc;

  assign w_cnt_ext   = {1'b0, cnt_in};
  assign w_prev_ext  = {1'b0, r_prev};
  assign w_prev_last = (w_prev_ext == LP_LAST);
  assign w_exp       = w_prev_last ? '0
                     : w_prev_ext + LP_ONE;
  assign w_correct   = (w_cnt_ext < LP_MOD)
                     && (w_cnt_ext == w_exp);
  assign w_run_inc   = r_run + LP_RUN_ONE;

  always_comb begin
    w_state_nxt      = r_state;
    w_have_prev_nxt  = r_have_prev;
    w_run_nxt        = r_run;
    w_prev_nxt       = r_prev;
    w_wrap_pulse_nxt = 1'b0;
    w_wrap_count_nxt = r_wrap_count;
    w_err_pulse_nxt  = 1'b0;
    w_err_sticky_nxt = r_err_sticky;
    w_err_count_nxt  = r_err_count;
    w_seq_err        = 1'b0;

    if (cnt_valid) begin
      unique case (r_state)
        ACQ: begin
          w_prev_nxt      = cnt_in;
          w_have_prev_nxt = 1'b1;
          // The first sample only seeds prev.
          if (r_have_prev) begin
            if (!w_correct) begin
              w_run_nxt = '0;
            end else if (w_run_inc == LP_LOCK_LEN) begin
              w_state_nxt = LOCK;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end
        end
        LOCK: begin
          if (w_correct) begin
            w_prev_nxt = cnt_in;
            if (w_prev_last) begin
              w_wrap_pulse_nxt = 1'b1;
              w_wrap_count_nxt = r_wrap_count
                               + LP_CNT_ONE;
            end
          end else begin
            // The bad sample seeds the resync.
            w_seq_err       = 1'b1;
            w_err_pulse_nxt = 1'b1;
            w_state_nxt     = ACQ;
            w_run_nxt       = '0;
            w_have_prev_nxt = 1'b1;
            w_prev_nxt      = cnt_in;
          end
        end
        default: begin
          w_state_nxt = ACQ;
        end
      endcase
    end

    // A same-cycle error beats err_clr.
    if (w_seq_err) begin
      w_err_sticky_nxt = 1'b1;
      if (err_clr) begin
        w_err_count_nxt = LP_CNT_ONE;
      end else if (r_err_count != LP_CNT_MAX) begin
        w_err_count_nxt = r_err_count + LP_CNT_ONE;
      end
    end else if (err_clr) begin
      w_err_sticky_nxt = 1'b0;
      w_err_count_nxt  = '0;
    end

    w_locked_nxt = (w_state_nxt == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACQ;
      r_have_prev  <= 1'b0;
      r_run        <= '0;
      r_prev       <= '0;
      r_locked     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_have_prev  <= w_have_prev_nxt;
      r_run        <= w_run_nxt;
      r_prev       <= w_prev_nxt;
      r_locked     <= w_locked_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_err_sticky <= w_err_sticky_nxt;
      r_err_count  <= w_err_count_nxt;
    end
  end

  assign locked     = r_locked;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_mod9_seq_checker.sv
// Scoreboard bench for mod9_seq_checker.
// Driver pushes hand-derived expectations; monitor pops and compares.

module tb_mod9_seq_checker;

  logic       clk;
  logic       rst;
  logic [4:0] cnt_in;
  logic       cnt_valid;
  logic       err_clr;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_count;

  typedef struct packed {
    logic       lk;
    logic       wp;
    logic [7:0] wc;
    logic       ep;
    logic       es;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mod9_seq_checker dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .err_clr    (err_clr),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input int a,
                     input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               n, a, e, $time);
    end
  endtask

  // Monitor: every sampled edge has one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("wrap_pulse", int'(wrap_pulse), int'(e.wp));
        chk("wrap_count", int'(wrap_count), int'(e.wc));
        chk("err_pulse", int'(err_pulse), int'(e.ep));
        chk("err_sticky", int'(err_sticky), int'(e.es));
        chk("err_count", int'(err_count), int'(e.ec));
      end
    end
  end

  task automatic step(input logic r, input logic v,
                      input logic clr, input int c,
                      input logic el, input logic ewp,
                      input int ewc, input logic eep,
                      input logic ees, input int eec);
    exp_t e;
    @(negedge clk);
    rst       = r;
    cnt_valid = v;
    err_clr   = clr;
    cnt_in    = 5'(c);
    e.lk = el;
    e.wp = ewp;
    e.wc = 8'(ewc);
    e.ep = eep;
    e.es = ees;
    e.ec = 8'(eec);
    q.push_back(e);
  endtask

  // Valid sample, locked afterwards, no pulses.
  task automatic lk(input int c, input int wc,
                    input int ec, input logic es);
    step(1'b0, 1'b1, 1'b0, c, 1'b1, 1'b0,
         wc, 1'b0, es, ec);
  endtask

  // Valid sample, not locked afterwards, no pulses.
  task automatic aq(input int c, input int wc,
                    input int ec, input logic es);
    step(1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0,
         wc, 1'b0, es, ec);
  endtask

  initial begin
    int ec;
    bit drained;
    rst = 1'b0;
    cnt_valid = 1'b0;
    err_clr = 1'b0;
    cnt_in = '0;

    // Reset and acquire
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    aq(0, 0, 0, 0);
    aq(1, 0, 0, 0);
    aq(2, 0, 0, 0);
    lk(3, 0, 0, 0);

    // Wraps
    for (int c = 4; c <= 8; c++) lk(c, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    for (int c = 1; c <= 8; c++) lk(c, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 2, 0, 0, 0);

    // Sequence error at prev=2, resync 6,7,8
    lk(1, 2, 0, 0);
    lk(2, 2, 0, 0);
    step(0, 1, 0, 5, 0, 0, 2, 1, 1, 1);
    aq(6, 2, 1, 1);
    aq(7, 2, 1, 1);
    lk(8, 2, 1, 1);

    // Gaps then out-of-range at prev=4
    step(0, 1, 0, 0, 1, 1, 3, 0, 1, 1);
    for (int c = 1; c <= 4; c++) lk(c, 3, 1, 1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 12, 1, 0, 3, 0, 1, 1);
    step(0, 1, 0, 12, 0, 0, 3, 1, 1, 2);
    aq(12, 3, 2, 1);
    aq(0, 3, 2, 1);
    aq(1, 3, 2, 1);
    aq(2, 3, 2, 1);
    lk(3, 3, 2, 1);

    // Saturation: repeated error from prev=8
    for (int c = 4; c <= 8; c++) lk(c, 3, 2, 1);
    ec = 2;
    for (int i = 0; i < 254; i++) begin
      ec = (ec < 255) ? ec + 1 : 255;
      step(0, 1, 0, 5, 0, 0, 3, 1, 1, ec);
      aq(6, 3, ec, 1);
      aq(7, 3, ec, 1);
      lk(8, 3, ec, 1);
    end

    // Clear alone, then clear with an error
    step(0, 0, 1, 0, 1, 0, 3, 0, 0, 0);
    step(0, 1, 1, 5, 0, 0, 3, 1, 1, 1);
    aq(6, 3, 1, 1);
    aq(7, 3, 1, 1);
    lk(8, 3, 1, 1);

    // Build wc=5, ec=2, then reset mid-lock
    step(0, 1, 0, 0, 1, 1, 4, 0, 1, 1);
    for (int c = 1; c <= 8; c++) lk(c, 4, 1, 1);
    step(0, 1, 0, 0, 1, 1, 5, 0, 1, 1);
    step(0, 1, 0, 5, 0, 0, 5, 1, 1, 2);
    aq(6, 5, 2, 1);
    aq(7, 5, 2, 1);
    lk(8, 5, 2, 1);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    aq(0, 0, 0, 0);
    aq(1, 0, 0, 0);
    aq(2, 0, 0, 0);
    lk(3, 0, 0, 0);

    @(negedge clk);
    cnt_valid = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, expected 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
